// File: rtl/deserializer_flex.sv
// deserializer_flex: packs DIN_WIDTH-bit input beats into a DATA_BUS_WIDTH word.
// MSB_FIRST selects whether the first beat fills the top or the bottom of the word.
// data_last_i flushes a partial word early; unwritten positions read as zero.
// Valid/ready handshakes on both sides; a held output word stalls the input.
// Optional: define DESERIALIZER_FLEX_STATS_EN to add deser_word_cnt_o, a saturating
// count of consumed output words.
module deserializer_flex #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DIN_WIDTH      = 1,
  parameter int MSB_FIRST      = 1,
  localparam int BEATS         = DATA_BUS_WIDTH / DIN_WIDTH,
  localparam int MOD_W         = $clog2(BEATS + 1)
) (
  input  logic                      clk_i,
  input  logic                      srst_n_i,
  input  logic [DIN_WIDTH-1:0]      data_i,
  input  logic                      data_val_i,
  input  logic                      data_last_i,
  output logic                      data_ready_o,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [MOD_W-1:0]          deser_data_mod_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_ready_i
`ifdef DESERIALIZER_FLEX_STATS_EN
  ,
  output logic [15:0]               deser_word_cnt_o
`endif
);

  // The word width must be an exact multiple of the beat width.
  if ((DATA_BUS_WIDTH % DIN_WIDTH) != 0) begin : g_width_check
    $error("deserializer_flex: DATA_BUS_WIDTH must be a multiple of DIN_WIDTH");
  end

  logic [MOD_W-1:0]          cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic [MOD_W-1:0]          mod_q, mod_d;
  logic                      val_q, val_d;

  logic [DATA_BUS_WIDTH-1:0] word_with_beat;
  logic                      accept;
  logic                      complete;
  logic                      consume;

  // Handshake qualifiers: input stalls only while an unconsumed word is held.
  always_comb begin
    data_ready_o = srst_n_i && (!val_q || deser_data_ready_i);
    accept       = data_val_i && data_ready_o;
    consume      = val_q && deser_data_ready_i;
    complete     = accept && ((cnt_q == MOD_W'(BEATS - 1)) || data_last_i);
  end

  // Accumulator contents with the current beat dropped into slot cnt_q.
  always_comb begin
    word_with_beat = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == MOD_W'(k)) begin
        if (MSB_FIRST != 0) begin
          word_with_beat[DATA_BUS_WIDTH-1-k*DIN_WIDTH -: DIN_WIDTH] = data_i;
        end else begin
          word_with_beat[k*DIN_WIDTH +: DIN_WIDTH] = data_i;
        end
      end
    end
  end

  // Next-state for beat counter, accumulator and output word registers.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = val_q;
    if (consume) begin
      val_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        cnt_d  = '0;
        acc_d  = '0;
        data_d = word_with_beat;
        mod_d  = cnt_q + MOD_W'(1);
        val_d  = 1'b1;
      end else begin
        cnt_d  = cnt_q + MOD_W'(1);
        acc_d  = word_with_beat;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      mod_q  <= mod_d;
      val_q  <= val_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;

`ifdef DESERIALIZER_FLEX_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Count consumed words, sticking at the maximum instead of wrapping.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (consume && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  // Word counter register.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign deser_word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer_flex.sv
// tb_deserializer_flex: directed tests for deserializer_flex in four configurations
// (4-bit beats MSB-first and LSB-first sharing stimulus, 1-bit beats, 16-bit beats).
module tb_deserializer_flex;

  logic clk;
  logic srst_n;
  int   checks;
  int   errors;

  logic [3:0]  d4;
  logic        v4, l4, rdy4;
  logic        r4m, r4l, ov4m, ov4l;
  logic [15:0] o4m, o4l;
  logic [2:0]  m4m, m4l;

  logic        d1, v1, l1, rdy1, r1, ov1;
  logic [15:0] o1;
  logic [4:0]  m1;

  logic [15:0] d16;
  logic        v16, l16, rdy16, r16, ov16;
  logic [15:0] o16;
  logic [0:0]  m16;

`ifdef DESERIALIZER_FLEX_STATS_EN
  logic [15:0] w4m, w4l, w1, w16;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  deserializer_flex #(.DATA_BUS_WIDTH(16), .DIN_WIDTH(4), .MSB_FIRST(1)) u_dut4m (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d4), .data_val_i(v4), .data_last_i(l4),
    .data_ready_o(r4m), .deser_data_o(o4m), .deser_data_mod_o(m4m),
    .deser_data_val_o(ov4m), .deser_data_ready_i(rdy4)
`ifdef DESERIALIZER_FLEX_STATS_EN
    , .deser_word_cnt_o(w4m)
`endif
  );

  deserializer_flex #(.DATA_BUS_WIDTH(16), .DIN_WIDTH(4), .MSB_FIRST(0)) u_dut4l (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d4), .data_val_i(v4), .data_last_i(l4),
    .data_ready_o(r4l), .deser_data_o(o4l), .deser_data_mod_o(m4l),
    .deser_data_val_o(ov4l), .deser_data_ready_i(rdy4)
`ifdef DESERIALIZER_FLEX_STATS_EN
    , .deser_word_cnt_o(w4l)
`endif
  );

  deserializer_flex #(.DATA_BUS_WIDTH(16), .DIN_WIDTH(1), .MSB_FIRST(1)) u_dut1 (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d1), .data_val_i(v1), .data_last_i(l1),
    .data_ready_o(r1), .deser_data_o(o1), .deser_data_mod_o(m1),
    .deser_data_val_o(ov1), .deser_data_ready_i(rdy1)
`ifdef DESERIALIZER_FLEX_STATS_EN
    , .deser_word_cnt_o(w1)
`endif
  );

  deserializer_flex #(.DATA_BUS_WIDTH(16), .DIN_WIDTH(16), .MSB_FIRST(1)) u_dut16 (
    .clk_i(clk), .srst_n_i(srst_n), .data_i(d16), .data_val_i(v16), .data_last_i(l16),
    .data_ready_o(r16), .deser_data_o(o16), .deser_data_mod_o(m16),
    .deser_data_val_o(ov16), .deser_data_ready_i(rdy16)
`ifdef DESERIALIZER_FLEX_STATS_EN
    , .deser_word_cnt_o(w16)
`endif
  );

  // Drive one valid 4-bit beat at the next falling edge.
  task automatic beat4(input logic [3:0] b, input logic last);
    @(negedge clk);
    v4 = 1'b1;
    d4 = b;
    l4 = last;
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    rdy4 = 1'b1; rdy1 = 1'b1; rdy16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (r4m !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", r4m); end
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL reset_val: got %b expected 0", ov4m); end
    checks++; if (o4m !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", o4m); end
    checks++; if (m4m !== 3'd0) begin errors++; $display("[TB] FAIL reset_mod: got %0d expected 0", m4m); end
    checks++; if (ov1 !== 1'b0 || ov16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_val_others: got %b%b expected 00", ov1, ov16); end
    srst_n = 1'b1;
    @(negedge clk);
    checks++; if (r4m !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", r4m); end
`ifdef DESERIALIZER_FLEX_STATS_EN
    checks++; if (w4m !== 16'd0) begin errors++; $display("[TB] FAIL reset_word_cnt: got %0d expected 0", w4m); end
`endif
  endtask

  task automatic test_full_word();
    beat4(4'hA, 1'b0);
    beat4(4'hB, 1'b0);
    beat4(4'hC, 1'b0);
    beat4(4'hD, 1'b0);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL partial_no_val: got %b expected 0", ov4m); end
    @(negedge clk);
    v4 = 1'b0;
    checks++; if (ov4m !== 1'b1) begin errors++; $display("[TB] FAIL full_val: got %b expected 1", ov4m); end
    checks++; if (o4m !== 16'hABCD) begin errors++; $display("[TB] FAIL full_msb_data: got %h expected abcd", o4m); end
    checks++; if (m4m !== 3'd4) begin errors++; $display("[TB] FAIL full_msb_mod: got %0d expected 4", m4m); end
    checks++; if (o4l !== 16'hDCBA) begin errors++; $display("[TB] FAIL full_lsb_data: got %h expected dcba", o4l); end
    checks++; if (m4l !== 3'd4) begin errors++; $display("[TB] FAIL full_lsb_mod: got %0d expected 4", m4l); end
    @(negedge clk);
    checks++; if (ov4m !== 1'b0 || ov4l !== 1'b0) begin errors++; $display("[TB] FAIL full_val_drop: got %b%b expected 00", ov4m, ov4l); end
  endtask

  task automatic test_last_flush();
    beat4(4'h1, 1'b0);
    beat4(4'h2, 1'b1);
    beat4(4'h3, 1'b0);
    checks++; if (ov4m !== 1'b1) begin errors++; $display("[TB] FAIL flush_val: got %b expected 1", ov4m); end
    checks++; if (o4m !== 16'h1200) begin errors++; $display("[TB] FAIL flush_msb_data: got %h expected 1200", o4m); end
    checks++; if (m4m !== 3'd2) begin errors++; $display("[TB] FAIL flush_mod: got %0d expected 2", m4m); end
    checks++; if (o4l !== 16'h0021) begin errors++; $display("[TB] FAIL flush_lsb_data: got %h expected 0021", o4l); end
    beat4(4'h4, 1'b0);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL flush_consumed: got %b expected 0", ov4m); end
    beat4(4'h5, 1'b0);
    beat4(4'h6, 1'b0);
    @(negedge clk);
    v4 = 1'b0;
    checks++; if (o4m !== 16'h3456 || m4m !== 3'd4) begin errors++; $display("[TB] FAIL after_flush_msb: got %h/%0d expected 3456/4", o4m, m4m); end
    checks++; if (o4l !== 16'h6543) begin errors++; $display("[TB] FAIL after_flush_lsb: got %h expected 6543", o4l); end
    // single-beat word: last with counter at zero
    beat4(4'h7, 1'b1);
    @(negedge clk);
    v4 = 1'b0;
    l4 = 1'b1;
    checks++; if (o4m !== 16'h7000 || m4m !== 3'd1 || ov4m !== 1'b1) begin errors++; $display("[TB] FAIL one_beat_msb: got %h/%0d/%b expected 7000/1/1", o4m, m4m, ov4m); end
    checks++; if (o4l !== 16'h0007 || m4l !== 3'd1) begin errors++; $display("[TB] FAIL one_beat_lsb: got %h/%0d expected 0007/1", o4l, m4l); end
    // last without valid is ignored; last on the final beat gives a full word
    beat4(4'h1, 1'b0);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL last_without_valid: got %b expected 0", ov4m); end
    beat4(4'h2, 1'b0);
    beat4(4'h3, 1'b0);
    beat4(4'h4, 1'b1);
    @(negedge clk);
    v4 = 1'b0;
    l4 = 1'b0;
    checks++; if (o4m !== 16'h1234 || m4m !== 3'd4 || ov4m !== 1'b1) begin errors++; $display("[TB] FAIL last_on_final: got %h/%0d/%b expected 1234/4/1", o4m, m4m, ov4m); end
  endtask

  task automatic test_back_to_back();
    beat4(4'h5, 1'b1);
    beat4(4'h6, 1'b1);
    checks++; if (ov4m !== 1'b1 || o4m !== 16'h5000) begin errors++; $display("[TB] FAIL b2b_first: got %b/%h expected 1/5000", ov4m, o4m); end
    beat4(4'h9, 1'b1);
    checks++; if (ov4m !== 1'b1 || o4m !== 16'h6000) begin errors++; $display("[TB] FAIL b2b_second: got %b/%h expected 1/6000", ov4m, o4m); end
    @(negedge clk);
    v4 = 1'b0;
    l4 = 1'b0;
    checks++; if (ov4m !== 1'b1 || o4m !== 16'h9000) begin errors++; $display("[TB] FAIL b2b_third: got %b/%h expected 1/9000", ov4m, o4m); end
    @(negedge clk);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drop: got %b expected 0", ov4m); end
  endtask

  task automatic test_backpressure();
    beat4(4'hA, 1'b0);
    beat4(4'hB, 1'b0);
    beat4(4'hC, 1'b0);
    beat4(4'hD, 1'b0);
    @(negedge clk);
    checks++; if (ov4m !== 1'b1 || o4m !== 16'hABCD) begin errors++; $display("[TB] FAIL bp_word: got %b/%h expected 1/abcd", ov4m, o4m); end
    rdy4 = 1'b0;
    d4 = 4'h1;
    #1;
    checks++; if (r4m !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", r4m); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ov4m !== 1'b1 || o4m !== 16'hABCD || m4m !== 3'd4) begin errors++; $display("[TB] FAIL bp_hold: got %b/%h/%0d expected 1/abcd/4", ov4m, o4m, m4m); end
      checks++; if (r4m !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_hold: got %b expected 0", r4m); end
    end
    rdy4 = 1'b1;
    #1;
    checks++; if (r4m !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_release: got %b expected 1", r4m); end
    beat4(4'h2, 1'b0);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL bp_consumed: got %b expected 0", ov4m); end
    beat4(4'h3, 1'b0);
    beat4(4'h4, 1'b0);
    @(negedge clk);
    v4 = 1'b0;
    checks++; if (ov4m !== 1'b1 || o4m !== 16'h1234 || m4m !== 3'd4) begin errors++; $display("[TB] FAIL bp_stalled_word: got %b/%h/%0d expected 1/1234/4", ov4m, o4m, m4m); end
    checks++; if (o4l !== 16'h4321) begin errors++; $display("[TB] FAIL bp_stalled_lsb: got %h expected 4321", o4l); end
    @(negedge clk);
  endtask

  task automatic test_reset_midword();
    beat4(4'h1, 1'b0);
    beat4(4'h2, 1'b0);
    @(negedge clk);
    v4 = 1'b0;
    srst_n = 1'b0;
    @(negedge clk);
    checks++; if (ov4m !== 1'b0 || r4m !== 1'b0) begin errors++; $display("[TB] FAIL midreset_during: got val %b ready %b expected 0 0", ov4m, r4m); end
    srst_n = 1'b1;
    @(negedge clk);
    checks++; if (ov4m !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after: got %b expected 0", ov4m); end
    beat4(4'h9, 1'b0);
    beat4(4'h8, 1'b0);
    beat4(4'h7, 1'b0);
    beat4(4'h6, 1'b0);
    @(negedge clk);
    v4 = 1'b0;
    checks++; if (ov4m !== 1'b1 || o4m !== 16'h9876 || m4m !== 3'd4) begin errors++; $display("[TB] FAIL midreset_word: got %b/%h/%0d expected 1/9876/4", ov4m, o4m, m4m); end
    checks++; if (o4l !== 16'h6789) begin errors++; $display("[TB] FAIL midreset_lsb: got %h expected 6789", o4l); end
  endtask

  task automatic test_din1_stream();
    logic [31:0] stream;
    stream = {16'hA5C3, 16'h1E96};
    rdy1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks++; if (ov1 !== 1'b1 || o1 !== 16'hA5C3 || m1 !== 5'd16) begin errors++; $display("[TB] FAIL din1_word0: got %b/%h/%0d expected 1/a5c3/16", ov1, o1, m1); end
      end else if (i > 0) begin
        checks++; if (ov1 !== 1'b0) begin errors++; $display("[TB] FAIL din1_idle_val: at bit %0d got %b expected 0", i, ov1); end
      end
      d1 = stream[31-i];
      v1 = 1'b1;
    end
    @(negedge clk);
    v1 = 1'b0;
    checks++; if (ov1 !== 1'b1 || o1 !== 16'h1E96 || m1 !== 5'd16) begin errors++; $display("[TB] FAIL din1_word1: got %b/%h/%0d expected 1/1e96/16", ov1, o1, m1); end
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("[TB] FAIL din1_drop: got %b expected 0", ov1); end
`ifdef DESERIALIZER_FLEX_STATS_EN
    checks++; if (w1 !== 16'd2) begin errors++; $display("[TB] FAIL din1_word_cnt: got %0d expected 2", w1); end
`endif
  endtask

  task automatic test_single_beat();
    rdy16 = 1'b1;
    @(negedge clk);
    d16 = 16'hBEEF;
    v16 = 1'b1;
    @(negedge clk);
    checks++; if (ov16 !== 1'b1 || o16 !== 16'hBEEF || m16 !== 1'b1) begin errors++; $display("[TB] FAIL slice_first: got %b/%h/%0d expected 1/beef/1", ov16, o16, m16); end
    d16 = 16'h1234;
    @(negedge clk);
    checks++; if (o16 !== 16'h1234 || ov16 !== 1'b1) begin errors++; $display("[TB] FAIL slice_second: got %b/%h expected 1/1234", ov16, o16); end
    rdy16 = 1'b0;
    d16 = 16'h5678;
    #1;
    checks++; if (r16 !== 1'b0) begin errors++; $display("[TB] FAIL slice_ready_low: got %b expected 0", r16); end
    @(negedge clk);
    checks++; if (o16 !== 16'h1234 || ov16 !== 1'b1) begin errors++; $display("[TB] FAIL slice_hold: got %b/%h expected 1/1234", ov16, o16); end
    rdy16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    checks++; if (o16 !== 16'h5678 || ov16 !== 1'b1) begin errors++; $display("[TB] FAIL slice_reload: got %b/%h expected 1/5678", ov16, o16); end
    @(negedge clk);
    checks++; if (ov16 !== 1'b0) begin errors++; $display("[TB] FAIL slice_drop: got %b expected 0", ov16); end
`ifdef DESERIALIZER_FLEX_STATS_EN
    checks++; if (w16 !== 16'd3) begin errors++; $display("[TB] FAIL slice_word_cnt: got %0d expected 3", w16); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    srst_n = 1'b0;
    d4 = '0; v4 = 1'b0; l4 = 1'b0; rdy4 = 1'b1;
    d1 = 1'b0; v1 = 1'b0; l1 = 1'b0; rdy1 = 1'b1;
    d16 = '0; v16 = 1'b0; l16 = 1'b0; rdy16 = 1'b1;
    test_reset();
    test_full_word();
    test_last_flush();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    test_din1_stream();
    test_single_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
